// File: rtl/reg_dump_renderer_pkg.sv
// Shared definitions for the register dump renderer: FSM encodings, default
// colours and the text-buffer word packing helper.
package reg_dump_renderer_pkg;

  typedef enum logic [7:0] {
    S_IDLE  = 8'h00,
    S_ADDR  = 8'h01,
    S_CMP   = 8'h02,
    S_WRITE = 8'h03,
    S_NEXT  = 8'h04,
    S_DONE  = 8'hFE,
    S_ERR   = 8'hFF
  } state_e;

  localparam logic [23:0] DEF_NORMAL_COLOR  = 24'hFFFFFF;
  localparam logic [23:0] DEF_CHANGED_COLOR = 24'hFF4040;

  function automatic logic [31:0] pack_char(input logic [7:0] ch, input logic [23:0] colour);
    return {ch, colour};
  endfunction

endpackage

// File: rtl/reg_dump_renderer_if.sv
// Bus bundle between the renderer, the register-file read port and the
// text-buffer write port. The renderer is the master of both.
interface reg_dump_renderer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int RF_AW  = 5
);
  logic              start;
  logic              full_refresh;
  logic              busy;
  logic              done;
  logic [RF_AW-1:0]  rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              ascii_write_en;
  logic [31:0]       ascii_input;
  logic [ADDR_W-1:0] ascii_write_address;

  modport master (
    input  start, full_refresh, rf_data,
    output rf_addr, ascii_write_en, ascii_input, ascii_write_address, busy, done
  );

  modport slave (
    output start, full_refresh, rf_data,
    input  rf_addr, ascii_write_en, ascii_input, ascii_write_address, busy, done
  );
endinterface

// File: rtl/reg_dump_renderer_nibble_to_hex.sv
// Converts one 4-bit nibble into its uppercase ASCII hex character.
module reg_dump_renderer_nibble_to_hex (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/reg_dump_renderer.sv
// Renders NUM_REGS register-file words as hex text into the ASCII buffer,
// highlighting values that changed since the previous frame.
module reg_dump_renderer
  import reg_dump_renderer_pkg::*;
#(
  parameter int          NUM_REGS      = 32,
  parameter int          DATA_W        = 32,
  parameter int          ADDR_W        = 13,
  parameter int          RF_AW         = 5,
  parameter int          REGS_PER_COL  = 16,
  parameter int          FIELD_BASE    = 1069,
  parameter int          COL_STRIDE    = 23,
  parameter int          ROW_STRIDE    = 160,
  parameter int          RF_LAT        = 0,
  parameter logic [23:0] NORMAL_COLOR  = DEF_NORMAL_COLOR,
  parameter logic [23:0] CHANGED_COLOR = DEF_CHANGED_COLOR
) (
  input logic                 clk,
  input logic                 rst,
  reg_dump_renderer_if.master bus
);

  localparam int DIGITS = DATA_W / 4;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WAIT_W = $clog2(RF_LAT + 2);
  localparam int ROW_W  = (REGS_PER_COL > 1) ? $clog2(REGS_PER_COL) : 1;

  localparam logic [RF_AW-1:0]  LAST_IDX  = RF_AW'(NUM_REGS - 1);
  localparam logic [DIG_W-1:0]  LAST_DIG  = DIG_W'(DIGITS - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RF_LAT);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(REGS_PER_COL - 1);
  localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(FIELD_BASE);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(COL_STRIDE);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(ROW_STRIDE);

  state_e             state;
  logic               mode;
  logic [RF_AW-1:0]   idx;
  logic [ROW_W-1:0]   row;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [DIG_W-1:0]   digit;
  logic [ADDR_W-1:0]  col_base;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  wr_addr;
  logic [23:0]        color;
  logic               shadow_valid;
  logic [NUM_REGS-1:0] hl;

  logic [DATA_W-1:0]  shadow [NUM_REGS];
  logic [DATA_W-1:0]  value;

  logic [DATA_W-1:0]  cur_shadow;
  logic               chg;
  logic               need;
  logic [3:0]         nib;
  logic [7:0]         hex_char;

  always_comb begin
    cur_shadow = shadow[idx];
    chg        = shadow_valid && (bus.rf_data != cur_shadow);
    need       = !shadow_valid || mode || chg || hl[idx];
  end

  always_comb begin
    nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (DIG_W'(k) == digit) nib = value[k*4 +: 4];
    end
  end

  reg_dump_renderer_nibble_to_hex u_hex (
    .nibble (nib),
    .ascii  (hex_char)
  );

  // Data capture at the compare cycle: shadow copy and the value being printed.
  always_ff @(posedge clk) begin
    if (state == S_CMP) begin
      shadow[idx] <= bus.rf_data;
      value       <= bus.rf_data;
    end
  end

  // Control FSM with registered outputs; base address advances by running adds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= S_IDLE;
      mode                    <= 1'b0;
      idx                     <= '0;
      row                     <= '0;
      wait_cnt                <= '0;
      digit                   <= '0;
      col_base                <= '0;
      base                    <= '0;
      wr_addr                 <= '0;
      color                   <= '0;
      shadow_valid            <= 1'b0;
      hl                      <= '0;
      bus.rf_addr             <= '0;
      bus.ascii_write_en      <= 1'b0;
      bus.ascii_input         <= '0;
      bus.ascii_write_address <= '0;
      bus.busy                <= 1'b0;
      bus.done                <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mode        <= bus.full_refresh;
            idx         <= '0;
            row         <= '0;
            col_base    <= BASE0;
            base        <= BASE0;
            wait_cnt    <= WAIT_INIT;
            bus.rf_addr <= '0;
            bus.busy    <= 1'b1;
            state       <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (wait_cnt == '0) state <= S_CMP;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_CMP: begin
          hl[idx] <= chg;
          color   <= chg ? CHANGED_COLOR : NORMAL_COLOR;
          wr_addr <= base;
          digit   <= LAST_DIG;
          state   <= need ? S_WRITE : S_NEXT;
        end
        S_WRITE: begin
          bus.ascii_write_en      <= 1'b1;
          bus.ascii_input         <= pack_char(hex_char, color);
          bus.ascii_write_address <= wr_addr;
          wr_addr                 <= wr_addr + 1'b1;
          if (digit == '0) state <= S_NEXT;
          else             digit <= digit - 1'b1;
        end
        S_NEXT: begin
          bus.ascii_write_en <= 1'b0;
          if (idx == LAST_IDX) begin
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            idx         <= idx + 1'b1;
            bus.rf_addr <= idx + 1'b1;
            wait_cnt    <= WAIT_INIT;
            if (row == LAST_ROW) begin
              row      <= '0;
              col_base <= col_base + COL_STEP;
              base     <= col_base + COL_STEP;
            end else begin
              row  <= row + 1'b1;
              base <= base + ROW_STEP;
            end
            state <= S_ADDR;
          end
        end
        S_DONE: begin
          bus.done     <= 1'b0;
          bus.busy     <= 1'b0;
          shadow_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: begin
          bus.ascii_write_en <= 1'b0;
          bus.busy           <= 1'b0;
          bus.done           <= 1'b0;
          state              <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_renderer.sv
// Directed bench for reg_dump_renderer: default 32x32 instance plus a
// 8x16-bit instance with a two-cycle registered register-file read.
module tb_reg_dump_renderer;

  logic clk;
  logic rst;

  reg_dump_renderer_if #(.DATA_W(32), .ADDR_W(13), .RF_AW(5)) ifa ();
  reg_dump_renderer_if #(.DATA_W(16), .ADDR_W(13), .RF_AW(3)) ifb ();

  reg_dump_renderer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  reg_dump_renderer #(
    .NUM_REGS     (8),
    .DATA_W       (16),
    .ADDR_W       (13),
    .RF_AW        (3),
    .REGS_PER_COL (4),
    .RF_LAT       (2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_a [32];
  logic [15:0] mem_b [8];
  logic [15:0] rf_b_p1, rf_b_p2;

  assign ifa.rf_data = mem_a[ifa.rf_addr];

  always @(posedge clk) begin
    rf_b_p1 <= mem_b[ifb.rf_addr];
    rf_b_p2 <= rf_b_p1;
  end
  assign ifb.rf_data = rf_b_p2;

  // Text-buffer models and write logs
  logic [31:0] scr_a [8192];
  logic [31:0] scr_b [8192];
  logic [31:0] log_data_a [4096];
  logic [12:0] log_addr_a [4096];
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  always @(posedge clk) begin
    if (ifa.ascii_write_en) begin
      scr_a[ifa.ascii_write_address]  <= ifa.ascii_input;
      log_data_a[12'(wr_cnt_a)]       <= ifa.ascii_input;
      log_addr_a[12'(wr_cnt_a)]       <= ifa.ascii_write_address;
      wr_cnt_a                        <= wr_cnt_a + 1;
    end
    if (ifa.done) done_cnt_a <= done_cnt_a + 1;
    if (ifb.ascii_write_en) begin
      scr_b[ifb.ascii_write_address] <= ifb.ascii_input;
      wr_cnt_b                       <= wr_cnt_b + 1;
    end
    if (ifb.done) done_cnt_b <= done_cnt_b + 1;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_field(input string tag, input int base, input string s,
                             input logic [23:0] col, input logic sel_b);
    logic [31:0] got;
    for (int k = 0; k < s.len(); k++) begin
      got = sel_b ? scr_b[13'(base + k)] : scr_a[13'(base + k)];
      check($sformatf("%s[%0d]", tag, k), got, {s[k], col});
    end
  endtask

  // Start one frame on the default instance; spam keeps start high throughout.
  task automatic frame_a(input logic full, input logic spam, output int cycles,
                         output int strobes, output int dones, output int first);
    int w0, d0, n;
    w0 = wr_cnt_a;
    d0 = done_cnt_a;
    @(negedge clk);
    ifa.start        = 1'b1;
    ifa.full_refresh = full;
    @(posedge clk); #1;
    if (!spam) ifa.start = 1'b0;
    n = 1;
    while (!ifa.done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cycles  = n;
    strobes = wr_cnt_a - w0;
    dones   = done_cnt_a - d0;
    first   = w0;
  endtask

  int cyc, stb, dn, w0, d0, n, bad;
  string s_dead;
  logic [31:0] ld;

  initial begin
    rst = 1'b0;
    ifa.start = 1'b0; ifa.full_refresh = 1'b0;
    ifb.start = 1'b0; ifb.full_refresh = 1'b0;
    for (int i = 0; i < 32; i++) mem_a[i] = 32'(i) * 32'h11111111;
    mem_b = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFACE, 16'hBEEF, 16'h1357, 16'h2468};
    s_dead = "DEADBEEF";

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(ifa.busy), 0);
    check("rst_done",   32'(ifa.done), 0);
    check("rst_we",     32'(ifa.ascii_write_en), 0);
    check("rst_waddr",  32'(ifa.ascii_write_address), 0);
    check("rst_input",  ifa.ascii_input, 0);
    check("rst_rfaddr", 32'(ifa.rf_addr), 0);
    check("rst_b_busy", 32'(ifb.busy), 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // First frame: every register written in normal colour
    frame_a(1'b0, 1'b0, cyc, stb, dn, w0);
    check("f1_cycles", cyc, 353);
    check("f1_strobes", stb, 256);
    check("f1_dones", dn, 1);
    check_field("f1_r0", 1069, "00000000", 24'hFFFFFF, 1'b0);
    check_field("f1_r1", 1229, "11111111", 24'hFFFFFF, 1'b0);
    check_field("f1_r17", 1252, "22222221", 24'hFFFFFF, 1'b0);

    // Delta frame, nothing changed
    frame_a(1'b0, 1'b0, cyc, stb, dn, w0);
    check("f2_cycles", cyc, 97);
    check("f2_strobes", stb, 0);
    check("f2_dones", dn, 1);

    // One register changed: only it is rewritten, highlighted
    mem_a[5] = 32'hDEADBEEF;
    frame_a(1'b0, 1'b0, cyc, stb, dn, w0);
    check("f3_cycles", cyc, 105);
    check("f3_strobes", stb, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("f3_addr%0d", k), 32'(log_addr_a[12'(w0 + k)]), 32'(1869 + k));
      check($sformatf("f3_data%0d", k), log_data_a[12'(w0 + k)], {s_dead[k], 24'hFF4040});
    end

    // Highlight clears on the next delta frame, then nothing is written
    frame_a(1'b0, 1'b0, cyc, stb, dn, w0);
    check("f4_cycles", cyc, 105);
    check("f4_strobes", stb, 8);
    check_field("f4_r5", 1869, "DEADBEEF", 24'hFFFFFF, 1'b0);
    frame_a(1'b0, 1'b0, cyc, stb, dn, w0);
    check("f5_strobes", stb, 0);
    check("f5_cycles", cyc, 97);

    // Reset in the middle of a write burst
    @(negedge clk);
    ifa.start = 1'b1; ifa.full_refresh = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    n = 0;
    while (!ifa.ascii_write_en && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_we_seen", 32'(ifa.ascii_write_en), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_we",     32'(ifa.ascii_write_en), 0);
    check("mid_busy",   32'(ifa.busy), 0);
    check("mid_input",  ifa.ascii_input, 0);
    check("mid_waddr",  32'(ifa.ascii_write_address), 0);
    check("mid_rfaddr", 32'(ifa.rf_addr), 0);
    w0 = wr_cnt_a;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_wr", wr_cnt_a - w0, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // After reset the shadow is invalid: full write, no highlights
    mem_a[5] = 32'h12345678;
    frame_a(1'b0, 1'b0, cyc, stb, dn, w0);
    check("f6_cycles", cyc, 353);
    check("f6_strobes", stb, 256);
    bad = 0;
    for (int k = 0; k < stb; k++) begin
      ld = log_data_a[12'(w0 + k)];
      if (ld[23:0] != 24'hFFFFFF) bad++;
    end
    check("f6_colours", bad, 0);
    check_field("f6_r5", 1869, "12345678", 24'hFFFFFF, 1'b0);

    // start held high through busy and done: exactly one frame
    frame_a(1'b0, 1'b1, cyc, stb, dn, w0);
    check("f7_cycles", cyc, 97);
    check("f7_strobes", stb, 0);
    check("f7_dones", dn, 1);
    check("f7_idle", 32'(ifa.busy), 0);

    // Narrow instance with register-file latency
    w0 = wr_cnt_b;
    d0 = done_cnt_b;
    @(negedge clk);
    ifb.start = 1'b1; ifb.full_refresh = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    n = 1;
    while (!ifb.done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (10) @(posedge clk);
    #1;
    check("b_cycles", n, 73);
    check("b_strobes", wr_cnt_b - w0, 32);
    check("b_dones", done_cnt_b - d0, 1);
    check_field("b_r0", 1069, "0123", 24'hFFFFFF, 1'b1);
    check_field("b_r3", 1549, "CDEF", 24'hFFFFFF, 1'b1);
    check_field("b_r4", 1092, "FACE", 24'hFFFFFF, 1'b1);
    check_field("b_r7", 1572, "2468", 24'hFFFFFF, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
